// File: rtl/abs_diff_sad_acc.sv
// Streaming |a-b| accumulator: per-block sum of absolute differences, running maximum
// difference and beat count, with valid/ready on both the operand and the result side.
module abs_diff_sad_acc #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 7,
    parameter bit          SAT   = 1'b1,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sad,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam int unsigned ExtW = WIDTH + 1;
    localparam int unsigned SumW = ACC_W + 1;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               mode_q, mode_d;

    logic               accept;
    logic               first;
    logic               eff_mode;
    logic [ExtW-1:0]    ext_a, ext_b;
    logic [WIDTH-1:0]   diff;
    logic [SumW-1:0]    sum;
    logic [CNT_W-1:0]   cnt_next;
    logic               final_beat;

    assign out_valid = (state_q == StDone);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // Any beat not landing in ACC opens a new block (IDLE, or DONE while the result drains).
    assign first     = (state_q != StAcc);
    assign eff_mode  = first ? signed_mode : mode_q;

    always_comb begin
        ext_a = {eff_mode & in_a[WIDTH-1], in_a};
        ext_b = {eff_mode & in_b[WIDTH-1], in_b};
        diff  = '0;
        if ($signed(ext_a) >= $signed(ext_b)) begin
            diff = WIDTH'(ext_a - ext_b);
        end else begin
            diff = WIDTH'(ext_b - ext_a);
        end
    end

    assign sum        = {1'b0, acc_q} + SumW'(diff);
    assign cnt_next   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign final_beat = in_last || (cnt_next == CNT_W'(LEN));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        if (accept) begin
            cnt_d   = cnt_next;
            state_d = final_beat ? StDone : StAcc;
            if (first) begin
                mode_d = signed_mode;
                acc_d  = ACC_W'(diff);
                max_d  = diff;
                ovf_d  = 1'b0;
            end else begin
                max_d = (diff > max_q) ? diff : max_q;
                ovf_d = ovf_q | sum[ACC_W];
                if (SAT && sum[ACC_W]) begin
                    acc_d = '1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
            end
        end else if (out_valid && out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
        end
    end

    assign out_sad = acc_q;
    assign out_max = max_q;
    assign out_cnt = cnt_q;
    assign out_ovf = ovf_q;

endmodule

// File: doc/abs_diff_sad_acc.md
Name: abs_diff_sad_acc

Overview:
- Parametrised successor to the combinational 4-bit absolute-difference block.
- Accepts a stream of operand pairs (a, b) over a valid/ready handshake and computes |a-b| per beat in unsigned or two's-complement mode.
- Accumulates a sum of absolute differences (SAD), the running maximum difference and a beat count over a block of up to LEN beats, then presents the result on a valid/ready output.
- Sits in error-evaluation datapaths, where it compares an approximate result stream against an exact reference stream.

Parameters:
- WIDTH, 4: operand width in bits; each |a-b| is WIDTH bits unsigned.
- LEN, 8: maximum beats per block, LEN >= 1.
- ACC_W, 7: SAD accumulator width, ACC_W >= WIDTH.
- SAT, 1: 1 = accumulator saturates at all-ones; 0 = accumulator wraps modulo 2^ACC_W.
- CNT_W, 4: beat-count width, 2^CNT_W > LEN.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  WIDTH  operand a, LSB = bit 0.
- in_b  input  WIDTH  operand b, LSB = bit 0.
- in_last  input  1  this beat terminates the block early.
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned.
- out_valid  output  1  result registers hold a completed block.
- out_ready  input  1  downstream consumes the result.
- out_sad  output  ACC_W  sum of |a-b| over the block.
- out_max  output  WIDTH  largest |a-b| in the block.
- out_cnt  output  CNT_W  number of beats in the block.
- out_ovf  output  1  accumulator exceeded 2^ACC_W-1 during the block.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; accumulator, max, count, mode latch and all outputs go to 0.
  - Reset takes effect immediately. Any partial block is discarded; no result is emitted for it.
- Difference:
  - Unsigned: |a-b| = a>=b ? a-b : b-a.
  - Signed: the compare and subtract are done on sign-extended WIDTH+1-bit values; the magnitude always fits in WIDTH bits (e.g. W=4: |-8-7| = 15).
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - A result transfers when out_valid && out_ready.
- States:
  - IDLE: no beats accumulated.
  - ACC: 1..LEN-1 beats accumulated.
  - DONE: out_valid=1.
- First beat of a block (accepted in IDLE, or in DONE while out_ready=1):
  - Latch signed_mode for the whole block.
  - acc := d, max := d, cnt := 1.
  - If d is the final beat, go to DONE; otherwise go to ACC.
- Later beats (in ACC):
  - acc := acc+d, with saturation or wrap per SAT.
  - max := max(max, d); cnt := cnt+1.
  - signed_mode changes mid-block are ignored.
- Final beat: in_last=1 or cnt reaches LEN on this beat.
  - The next cycle, out_sad, out_max, out_cnt and out_ovf hold the block result and out_valid=1.
  - Latency from final-beat accept to out_valid is 1 cycle.
- DONE:
  - Outputs are held stable while out_ready=0; in_ready=0 in that case.
  - out_ready=1 and no beat accepted: go to IDLE with out_valid=0 next cycle. Output data regs may retain their values.
  - out_ready=1 and a beat accepted in the same cycle: the result is consumed and the new block starts with that beat, with no bubble.
  - If that new beat is itself final (LEN=1 or in_last), stay in DONE with the new result.
- Overflow:
  - out_ovf is set if any addition carries out of ACC_W, regardless of SAT.
  - With SAT=1, out_sad = 2^ACC_W-1 once overflow occurs.
- in_last on a beat in IDLE produces a one-beat block (cnt=1).

Test Plan:
- Unsigned, WIDTH=4, LEN=4: a={3,10,0,15}, b={5,2,0,0}, back-to-back -> 1 cycle after the 4th accept: out_valid=1, out_sad=25, out_max=15, out_cnt=4, out_ovf=0.
- Signed, early termination: a={1000b,1111b}, b={0111b,0001b}, in_last on beat 2 -> out_sad=17, out_max=15, out_cnt=2.
- Backpressure, part 1: hold out_ready=0 for 5 cycles after out_valid -> in_ready=0 and all outputs stable throughout.
- Backpressure, part 2: then out_ready=1 together with in_valid (a=9, b=4) -> the result drops and the new block starts that cycle; the next result reports the new block's beat 1 (d=5).
- Saturation: ACC_W=5, LEN=4, four beats of d=15 -> SAT=1 gives out_sad=31, out_ovf=1; SAT=0 gives out_sad=28, out_ovf=1.
- Reset mid-block: rst_n low after 2 accepted beats -> all outputs 0 immediately. Next block a={2}, b={7} with in_last -> out_sad=5, out_cnt=1.
- Mode latch: start the block with signed_mode=0, toggle it to 1 on beat 2, a=1111b, b=0000b -> beat 2 is treated as unsigned, d=15.
